instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Top-level control FSM of the simple CPU. Fetches 16-bit instructions from instruction memory
//  and decodes the opcode. Dispatches a one-cycle start pulse to the matching execution FSM
//  (Move, Add, ...) and holds the Ri/Rj operand fields stable while that unit runs.
//  Waits for that unit's done, then advances the PC. Detects HALT and hung units (timeout).
// PARAMETERS
//  PC_W     8   width of program counter / imem address
//  TIMEOUT  15  max WAIT cycles for unit done before FAULT (1..2^CNT_W-1)
//  CNT_W    4   width of timeout counter
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  reset      in   1     synchronous, active-low reset
//  run        in   1     level; 1 = execute from PC 0, 0 = return to IDLE from HALTED/FAULT
//  imem_addr  out  PC_W  instruction address (= pc)
//  imem_rd    out  1     read strobe; imem_data valid the cycle after
//  imem_data  in   16    instruction word {op[15:12], Ri[11:6], Rj[5:0]}
//  unit_start out  16    one-hot start pulse, bit = opcode
//  unit_done  in   16    done from each execution unit, bit = opcode
//  Ri         out  6     destination field, held from DISPATCH until ADVANCE
//  Rj         out  6     source field, held likewise
//  pc         out  PC_W  current program counter
//  busy       out  1     1 in any state except IDLE/HALTED/FAULT
//  halted     out  1     1 in HALTED
//  fault      out  1     1 in FAULT
// BEHAVIOUR
//  Reset (reset==0 at clk edge, overrides everything incl. mid-instruction):
//   state=IDLE, pc=0, ir=0, wait_cnt=0; all outputs 0 (unit_start=0, imem_rd=0, Ri=Rj=0).
//  All outputs are registered or decoded from state/ir only; no comb path from inputs to outputs.
//  States/transitions (one cycle each unless noted):
//   IDLE     : run=1 -> FETCH, pc<=0. else stay.
//   FETCH    : imem_rd=1, imem_addr=pc -> LATCH.
//   LATCH    : ir<=imem_data -> DECODE.
//   DECODE   : op=0 (NOP) -> ADVANCE. op=15 (HALT) -> HALTED. else -> DISPATCH.
//   DISPATCH : unit_start[op]=1 for exactly this cycle; wait_cnt<=0 -> WAIT.
//   WAIT     : unit_done[op]=1 -> ADVANCE. else wait_cnt++; wait_cnt==TIMEOUT-1 -> FAULT.
//              Only unit_done[op] is sampled; done from other units is ignored.
//              unit_done[op] already high in the DISPATCH cycle is ignored.
//   ADVANCE  : pc<=pc+1, mod 2^PC_W (wraps to 0) -> FETCH.
//   HALTED   : halted=1; pc holds the HALT address; run=0 -> IDLE.
//   FAULT    : fault=1; pc holds the faulting address; run=0 -> IDLE.
//  run going low during FETCH..ADVANCE is ignored; the program continues to HALT/FAULT.
//  Ri=ir[11:6], Rj=ir[5:0] are driven in DISPATCH and WAIT; 0 in all other states.
//  Latency: FETCH to unit_start = 3 cycles; NOP instr = 4 cycles; unit instr = 5 + done delay.
//  unit_start never has more than one bit set. unit_start[0] and unit_start[15] are never set.
// TESTING
//  1 reset=0 mid-WAIT -> next cycle state IDLE, all outputs 0, pc=0; run held 1 -> FETCH after.
//  2 imem[0]=0x7042, unit 7 done 2 cyc after start -> unit_start=0x0080 one cycle, Ri=1, Rj=2 held.
//    Same case: Ri/Rj held until done, pc becomes 1.
//  3 imem[0]=0x0000, imem[1]=0xF000 -> no unit_start; halted=1, pc=1, busy=0; run=0 -> IDLE.
//  4 imem[0]=0x2000, unit 2 never done, TIMEOUT=15 -> fault=1 exactly 15 cycles after DISPATCH; pc=0.
//  5 op 3 dispatched, unit_done=0x0010 (wrong unit) -> stays WAIT; unit_done=0x0008 -> ADVANCE.
//  6 PC_W=2, four NOPs, imem_data=0 always -> pc 0,1,2,3,0 wraps, never HALTED; busy=1 throughout.

Source files
------------

// File: rtl/instr_sequencer.sv
// Top-level control FSM of the simple CPU.
// Fetches a 16-bit instruction {op, Ri, Rj}, decodes the opcode, pulses the
// matching execution unit's start bit, and holds the operand fields while
// that unit runs. It waits for the unit's done, with a timeout, and then
// advances the PC. HALT (op 15) and hung units park the FSM until run drops.
// Every output is a flop or a direct copy of one, so inputs never reach outputs
// through combinational logic.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  output logic [15:0]     unit_start,
  input  logic [15:0]     unit_done,
  output logic [5:0]      Ri,
  output logic [5:0]      Rj,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_DISPATCH,
    S_WAIT,
    S_ADVANCE,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [3:0]       OP_NOP    = 4'h0;
  localparam logic [3:0]       OP_HALT   = 4'hF;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [15:0]      ir;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       op;

  // One-hot start mask for a unit opcode.
  function automatic logic [15:0] start_mask(input logic [3:0] code);
    start_mask = 16'h0001 << code;
  endfunction

  assign op        = ir[15:12];
  assign imem_addr = pc;

  // Sequencer FSM: each transition also loads the output flops with the values
  // belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      wait_cnt   <= '0;
      imem_rd    <= 1'b0;
      unit_start <= '0;
      Ri         <= '0;
      Rj         <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      // Read strobe and start pulse are single-cycle unless re-armed below.
      imem_rd    <= 1'b0;
      unit_start <= '0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_FETCH;
            pc      <= '0;
            imem_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          ir    <= imem_data;
          state <= S_DECODE;
        end

        S_DECODE: begin
          if (op == OP_NOP) begin
            state <= S_ADVANCE;
          end else if (op == OP_HALT) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state      <= S_DISPATCH;
            unit_start <= start_mask(op);
            Ri         <= ir[11:6];
            Rj         <= ir[5:0];
          end
        end

        // Done arriving during the start cycle is deliberately not looked at.
        S_DISPATCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        // Only the dispatched unit's done counts; it wins over the timeout.
        S_WAIT: begin
          if (unit_done[op]) begin
            state <= S_ADVANCE;
            Ri    <= '0;
            Rj    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == LAST_WAIT) begin
              state <= S_FAULT;
              busy  <= 1'b0;
              fault <= 1'b1;
              Ri    <= '0;
              Rj    <= '0;
            end
          end
        end

        S_ADVANCE: begin
          pc      <= pc + PC_W'(1);
          state   <= S_FETCH;
          imem_rd <= 1'b1;
        end

        // pc keeps the HALT address until run is released.
        S_HALTED: begin
          if (!run) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end

        // pc keeps the faulting address until run is released.
        S_FAULT: begin
          if (!run) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          Ri     <= '0;
          Rj     <= '0;
          busy   <= 1'b0;
          halted <= 1'b0;
          fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table-driven programs with a start/operand
// scoreboard, plus hand sequences for reset, timeout and PC wrap.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic [15:0] unit_start;
  logic [15:0] unit_done;
  logic [5:0]  Ri, Rj;
  logic [7:0]  pc;
  logic        busy, halted, fault;

  // Narrow-PC instance for the wrap test.
  logic        run2;
  logic [1:0]  imem_addr2, pc2;
  logic        imem_rd2;
  logic [15:0] unit_start2;
  logic [5:0]  Ri2, Rj2;
  logic        busy2, halted2, fault2;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] instr;
    int          dly;
    logic [15:0] noise;
    bit          early;
    logic [15:0] start;
    logic [5:0]  ri;
    logic [5:0]  rj;
  } vec_t;

  vec_t vecs [7];
  vec_t sb [$];

  instr_sequencer #(.PC_W(8), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .unit_start(unit_start), .unit_done(unit_done),
    .Ri(Ri), .Rj(Rj), .pc(pc),
    .busy(busy), .halted(halted), .fault(fault)
  );

  instr_sequencer #(.PC_W(2), .TIMEOUT(15), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .run(run2),
    .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(16'h0000),
    .unit_start(unit_start2), .unit_done(16'h0000),
    .Ri(Ri2), .Rj(Rj2), .pc(pc2),
    .busy(busy2), .halted(halted2), .fault(fault2)
  );

  always #5 clk = ~clk;

  // Instruction memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    run       = 1'b0;
    unit_done = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs",
          32'({imem_rd, unit_start, Ri, Rj, busy, halted, fault}), 32'h0);
    check("reset pc", 32'(pc), 32'h0);
    reset = 1'b1;
  endtask

  // Load vecs[first..first+n-1] followed by HALT, run it, score every dispatch.
  task automatic run_prog(input int first, input int n, input int exp_cycles);
    vec_t cur;
    int   cycles;
    int   pending;
    bit   waiting;
    bit   adv_chk;
    bit   first_start;
    for (int i = 0; i < n; i++) begin
      mem[i] = vecs[first + i].instr;
      if (vecs[first + i].instr[15:12] != 4'h0) sb.push_back(vecs[first + i]);
    end
    mem[n] = 16'hF000;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    cycles = 0; pending = 0; waiting = 0; adv_chk = 0; first_start = 1;
    while (!halted && !fault && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      unit_done = '0;
      if (adv_chk) begin
        check("Ri cleared after done", 32'(Ri), 32'h0);
        check("Rj cleared after done", 32'(Rj), 32'h0);
        adv_chk = 0;
      end
      if (unit_start != 16'h0) begin
        if (sb.size() == 0) begin
          check("unexpected unit_start", 32'(unit_start), 32'h0);
        end else begin
          cur = sb.pop_front();
          check("unit_start", 32'(unit_start), 32'(cur.start));
          check("Ri at dispatch", 32'(Ri), 32'(cur.ri));
          check("Rj at dispatch", 32'(Rj), 32'(cur.rj));
          if (first_start && first == 0) check("fetch-to-start latency", 32'(cycles), 32'd4);
          first_start = 0;
          waiting = 1;
          pending = cur.dly;
          unit_done = cur.noise | (cur.early ? (16'h0001 << cur.instr[15:12]) : 16'h0000);
        end
      end else if (waiting) begin
        check("Ri held", 32'(Ri), 32'(cur.ri));
        check("Rj held", 32'(Rj), 32'(cur.rj));
        pending--;
        if (pending == 0) begin
          unit_done = 16'h0001 << cur.instr[15:12];
          waiting = 0;
          adv_chk = 1;
        end else begin
          unit_done = cur.noise;
        end
      end
    end
    unit_done = '0;
    check("program cycles", 32'(cycles), 32'(exp_cycles));
    check("halted", 32'(halted), 32'h1);
    check("no fault", 32'(fault), 32'h0);
    check("busy in HALTED", 32'(busy), 32'h0);
    check("halt pc", 32'(pc), 32'(n));
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    sb.delete();
    run = 1'b0;
    @(negedge clk);
    check("HALTED to IDLE", 32'({halted, busy, fault}), 32'h0);
  endtask

  // Run until the first start pulse; a missing pulse is a failure.
  task automatic wait_start(input logic [15:0] exp_start);
    int cyc;
    cyc = 0;
    while (unit_start == 16'h0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("start pulse", 32'(unit_start), 32'(exp_start));
  endtask

  initial begin
    // instr, dly, noise, early, start, Ri, Rj
    vecs[0] = '{16'h7042, 2,  16'h0000, 1'b0, 16'h0080, 6'd1,  6'd2};
    vecs[1] = '{16'h0000, 0,  16'h0000, 1'b0, 16'h0000, 6'd0,  6'd0};
    vecs[2] = '{16'h30C5, 4,  16'h0010, 1'b0, 16'h0008, 6'd3,  6'd5};
    vecs[3] = '{16'h1FFF, 1,  16'h0000, 1'b1, 16'h0002, 6'd63, 6'd63};
    vecs[4] = '{16'hEABC, 3,  16'h8001, 1'b0, 16'h4000, 6'd42, 6'd60};
    vecs[5] = '{16'h5123, 15, 16'h0000, 1'b0, 16'h0020, 6'd4,  6'd35};
    vecs[6] = '{16'h0000, 0,  16'h0000, 1'b0, 16'h0000, 6'd0,  6'd0};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    imem_data = '0;
    run2 = 1'b0;

    // Mixed program: operand hold, wrong-unit done, early done, longest wait.
    run_prog(0, 6, 58);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // NOP then HALT: nothing dispatched, halts at address 1.
    run_prog(6, 1, 8);

    // Hung unit: 15 WAIT cycles, then FAULT with pc at the instruction.
    mem[0] = 16'h2A55;
    do_reset();
    @(negedge clk);
    run = 1'b1;
    wait_start(16'h0004);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        check("no fault before timeout", 32'(fault), 32'h0);
        check("busy while waiting", 32'(busy), 32'h1);
        check("Ri held while hung", 32'(Ri), 32'd41);
        check("Rj held while hung", 32'(Rj), 32'd21);
      end
      if (k == 16) begin
        check("fault after timeout", 32'(fault), 32'h1);
        check("fault pc", 32'(pc), 32'h0);
        check("busy in FAULT", 32'(busy), 32'h0);
        check("Ri cleared in FAULT", 32'(Ri), 32'h0);
      end
    end
    run = 1'b0;
    @(negedge clk);
    check("FAULT to IDLE", 32'({fault, busy, halted}), 32'h0);

    // Reset in the middle of WAIT, then restart with run still high.
    do_reset();
    @(negedge clk);
    run = 1'b1;
    wait_start(16'h0004);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid-WAIT reset outputs",
          32'({imem_rd, unit_start, Ri, Rj, busy, halted, fault}), 32'h0);
    check("mid-WAIT reset pc", 32'(pc), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("refetch strobe", 32'(imem_rd), 32'h1);
    check("refetch busy", 32'(busy), 32'h1);
    check("refetch addr", 32'(imem_addr), 32'h0);
    run = 1'b0;
    do_reset();

    // Two-bit PC running NOPs forever: wraps 3 -> 0 and never stops.
    @(negedge clk);
    run2 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("wrap pc", 32'(pc2), 32'(((k - 1) / 4) % 4));
      check("wrap busy", 32'({busy2, halted2, fault2}), 32'h4);
      check("wrap no start", 32'({unit_start2, Ri2, Rj2}), 32'h0);
      if (k % 4 == 1) begin
        check("wrap fetch strobe", 32'(imem_rd2), 32'h1);
        check("wrap fetch addr", 32'(imem_addr2), 32'(((k - 1) / 4) % 4));
      end
    end
    run2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
